uart_rx_fifo_param: RTL

//  Parametrised next-generation UART receiver for the clk16x (16x baud) domain.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_fifo_param_if.sv | 16 +
 rtl/uart_sync_fifo.sv | 40 ++++
 rtl/uart_rx_fifo_param.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and receiver state encoding
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [3:0] SAMPLE_LO = 4'd7;
  localparam logic [3:0] SAMPLE_HI = 4'd9;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo_param_if.sv
// uart_rx_fifo_param_if: CPU-side read port of the receiver
interface uart_rx_fifo_param_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W = 4
);
  logic                 rdn;
  logic [DATA_BITS-1:0] d_out;
  logic                 parity_error;
  logic                 frame_error;
  logic                 r_ready;
  logic                 overrun;
  logic                 break_det;
  logic [CNT_W-1:0]     fifo_count;
  modport master (output rdn, input d_out, parity_error, frame_error, r_ready, overrun, break_det, fifo_count);
  modport slave (input rdn, output d_out, parity_error, frame_error, r_ready, overrun, break_det, fifo_count);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO allowing push and pop in the same cycle
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk16x,
  input  logic             clrn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp];
  // storage has no reset: pointers and count alone decide what is valid
  always_ff @(posedge clk16x)
    if (do_push) mem[wp] <= wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk16x or negedge clrn)
    if (!clrn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
endmodule

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: 16x-oversampled UART receiver with parity, stop check, break detect and receive FIFO
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic       clk16x,
  input logic       clrn,
  input logic       rxd,
  input logic [1:0] cfg_parity,
  input logic       cfg_stop2,
  uart_rx_fifo_param_if.slave bus
);
  rx_state_t state, state_n;
  logic sync1, rxs, rdn_q, rd_strobe, pop, full, empty;
  logic [3:0] tick, nbit, nbit_n;
  logic [1:0] smp, par, par_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic stop2, stop2_n, stop_two, stop_two_n, pbit, pbit_n, perr, perr_n, ferr, ferr_n;
  logic push_q, push_n, brk_n, decide, bit_v, par_on;
  logic [DATA_BITS+1:0] head;
  logic [CNT_W-1:0] count;
  assign decide = tick == SAMPLE_HI && state != IDLE && state != BRK_WAIT;
  assign bit_v = (smp[0] & smp[1]) | (rxs & (smp[0] | smp[1]));
  assign par_on = par == PAR_EVEN || par == PAR_ODD;
  assign rd_strobe = ~bus.rdn & rdn_q;
  assign pop = rd_strobe & ~empty;
  assign bus.r_ready = ~empty;
  assign bus.fifo_count = count;
  // input synchroniser, bit-phase counter, mid-bit samples and read edge detect
  always_ff @(posedge clk16x or negedge clrn)
    if (!clrn) begin
      sync1 <= 1'b1;
      rxs <= 1'b1;
      rdn_q <= 1'b1;
      tick <= '0;
      smp <= '0;
    end else begin
      sync1 <= rxd;
      rxs <= sync1;
      rdn_q <= bus.rdn;
      tick <= state == IDLE ? 4'd0 : tick + 4'd1;
      smp <= tick == SAMPLE_LO ? {smp[1], rxs} : tick == SAMPLE_LO + 4'd1 ? {rxs, smp[0]} : smp;
    end
  // frame state and per-frame context registers
  always_ff @(posedge clk16x or negedge clrn)
    if (!clrn) begin
      state <= IDLE;
      sh <= '0;
      nbit <= '0;
      par <= PAR_NONE;
      stop2 <= 1'b0;
      stop_two <= 1'b0;
      pbit <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      push_q <= 1'b0;
      bus.break_det <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      nbit <= nbit_n;
      par <= par_n;
      stop2 <= stop2_n;
      stop_two <= stop_two_n;
      pbit <= pbit_n;
      perr <= perr_n;
      ferr <= ferr_n;
      push_q <= push_n;
      bus.break_det <= brk_n;
    end
  // next-state logic: each bit acts once, on its majority decision at SAMPLE_HI
  always_comb begin
    state_n = state;
    sh_n = sh;
    nbit_n = nbit;
    par_n = par;
    stop2_n = stop2;
    stop_two_n = stop_two;
    pbit_n = pbit;
    perr_n = perr;
    ferr_n = ferr;
    push_n = 1'b0;
    brk_n = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        nbit_n = '0;
        par_n = cfg_parity;
        stop2_n = cfg_stop2;
        stop_two_n = 1'b0;
        pbit_n = 1'b0;
        perr_n = 1'b0;
        ferr_n = 1'b0;
      end
      START: if (decide) state_n = bit_v ? IDLE : DATA;
      DATA: if (decide) begin
        sh_n = {bit_v, sh[DATA_BITS-1:1]};
        nbit_n = nbit + 4'd1;
        if (nbit == 4'(DATA_BITS - 1)) state_n = par_on ? PARITY : STOP;
      end
      PARITY: if (decide) begin
        pbit_n = bit_v;
        perr_n = ^{sh, bit_v} ^ (par == PAR_ODD);
        state_n = STOP;
      end
      STOP: if (decide) begin
        if (~stop_two & ~bit_v & ~|sh & ~pbit) begin
          brk_n = 1'b1;
          state_n = BRK_WAIT;
        end else begin
          ferr_n = ferr | ~bit_v;
          if (stop2 && !stop_two) stop_two_n = 1'b1;
          else begin
            push_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BRK_WAIT: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // popped word to the CPU outputs; overrun is sticky until any read strobe
  always_ff @(posedge clk16x or negedge clrn)
    if (!clrn) begin
      bus.d_out <= '0;
      bus.parity_error <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (pop) {bus.frame_error, bus.parity_error, bus.d_out} <= head;
      bus.overrun <= (push_q & full & ~pop) | (bus.overrun & ~rd_strobe);
    end
  uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk16x(clk16x),
    .clrn(clrn),
    .push(push_q),
    .pop(pop),
    .wdata({ferr, perr, sh}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule
